fft_stage_ctrl: RTL

//  Radix-2 DIT FFT sequencer that sits directly upstream of butterfly.
//  - Issues ping-pong RAM read addresses for N = 2**CMD_WIDTH points, one butterfly per cycle.
//  - Drives butterfly w (twiddle) and m_in ({addr_b, addr_a}) aligned with RAM read data.
//  - Emits wr_en aligned with butterfly m_out; input data is bit-reversed and loaded by others.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_twiddle_rom.sv | 76 +++++++
 rtl/fft_stage_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT sequencer: FSM state encoding,
// default geometry and helpers for the half-size and drain-length constants.
package fft_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int FFT_DEF_DATA_WIDTH = 8;
  localparam int FFT_DEF_CMD_WIDTH  = 3;
  localparam int FFT_DEF_BF_LATENCY = 3;

  // Butterflies per stage: N/2 with N = 2**cmd_width.
  function automatic int fft_half_n(input int cmd_width);
    return 1 << (cmd_width - 1);
  endfunction

  // Idle cycles between stages so the last write retires before the next read.
  function automatic int fft_drain_cycles(input int bf_latency);
    return bf_latency + 1;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle ROM for W_N^t, t = 0..N/2-1, in Q(DATA_WIDTH-2) fixed point.
// Entries are built at elaboration time; the output is registered (1-cycle
// latency) and only advances when en is high, so it holds between reads.
module fft_twiddle_rom #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [CMD_WIDTH-2:0]      idx,
  output logic [2*DATA_WIDTH-1:0]   w
);

  localparam int  HALF_N = 1 << (CMD_WIDTH - 1);
  localparam int  N      = 1 << CMD_WIDTH;
  localparam real SCALE  = real'(1 << (DATA_WIDTH - 2));
  localparam real PI     = 3.14159265358979323846;

  // Taylor series is exact enough for angles in [0, pi) at these widths.
  function automatic real tw_cos(input real x);
    real term;
    real sum;
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i < 14; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real tw_sin(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int i = 1; i < 14; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Round half away from zero.
  function automatic int tw_round(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(0.5 - v);
  endfunction

  logic [2*DATA_WIDTH-1:0] rom_tab [HALF_N];
  logic [2*DATA_WIDTH-1:0] w_d;
  logic [2*DATA_WIDTH-1:0] w_q;

  for (genvar t = 0; t < HALF_N; t++) begin : gen_rom
    localparam real ANG = 2.0 * PI * real'(t) / real'(N);
    localparam int  RE  = tw_round(tw_cos(ANG) * SCALE);
    localparam int  IM  = tw_round(-tw_sin(ANG) * SCALE);
    assign rom_tab[t] = {IM[DATA_WIDTH-1:0], RE[DATA_WIDTH-1:0]};
  end

  // Fetch the addressed entry on a read, otherwise hold the last twiddle.
  always_comb begin
    w_d = w_q;
    if (en) w_d = rom_tab[idx];
  end

  // Output register; cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_q <= '0;
    else        w_q <= w_d;
  end

  assign w = w_q;

endmodule

// File: rtl/fft_stage_ctrl.sv
// Radix-2 DIT FFT sequencer feeding a butterfly from ping-pong RAM.
// Per stage it reads N/2 butterfly pairs (one per cycle), then drains the
// butterfly pipeline before the next stage so read/write banks never overlap.
// Optional build macro FFT_INVERSE_EN adds an 'inverse' input that selects
// conjugate twiddles for the whole transform.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DEF_DATA_WIDTH,
  parameter int CMD_WIDTH  = FFT_DEF_CMD_WIDTH,
  parameter int BF_LATENCY = FFT_DEF_BF_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
`ifdef FFT_INVERSE_EN
  input  logic                    inverse,
`endif
  output logic                    rd_en,
  output logic [CMD_WIDTH-1:0]    rd_addr_a,
  output logic [CMD_WIDTH-1:0]    rd_addr_b,
  output logic                    rd_bank,
  output logic [2*DATA_WIDTH-1:0] w,
  output logic [2*CMD_WIDTH-1:0]  m_in,
  output logic                    wr_en,
  output logic [CMD_WIDTH-1:0]    stage,
  output logic                    busy,
  output logic                    done
);

  localparam int HALF_N       = fft_half_n(CMD_WIDTH);
  localparam int DRAIN_CYCLES = fft_drain_cycles(BF_LATENCY);
  localparam int KW           = CMD_WIDTH - 1;
  localparam int DCW          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [1:0]             state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [CMD_WIDTH-1:0]   stage_q, stage_d;
  logic [DCW-1:0]         drain_q, drain_d;
  logic [BF_LATENCY:0]    wr_pipe_q, wr_pipe_d;
  logic [2*CMD_WIDTH-1:0] m_in_q, m_in_d;
  logic                   inv_q, inv_d;

  logic                   run;
  logic [CMD_WIDTH-1:0]   k_ext;
  logic [CMD_WIDTH-1:0]   span;
  logic [CMD_WIDTH-1:0]   pos;
  logic [CMD_WIDTH-1:0]   addr_a;
  logic [CMD_WIDTH-1:0]   addr_b;
  logic [CMD_WIDTH-1:0]   tw_sh;
  logic [KW-1:0]          tw_idx;
  logic [2*DATA_WIDTH-1:0] w_rom;

  assign run = (state_q == ST_RUN);

  // Sequencing: IDLE -> RUN (N/2 reads) -> DRAIN -> next stage or DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    drain_d = drain_q;
    inv_d   = inv_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          k_d     = '0;
          stage_d = '0;
          drain_d = '0;
`ifdef FFT_INVERSE_EN
          inv_d   = inverse;
`else
          inv_d   = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (k_q == KW'(HALF_N - 1)) begin
          state_d = ST_DRAIN;
          k_d     = '0;
          drain_d = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
          drain_d = '0;
          if (stage_q == CMD_WIDTH'(CMD_WIDTH - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + CMD_WIDTH'(1);
          end
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        stage_d = '0;
        inv_d   = 1'b0;
      end
    endcase
  end

  // Butterfly pair and twiddle index for the current k and stage.
  always_comb begin
    k_ext  = {1'b0, k_q};
    span   = CMD_WIDTH'(1) << stage_q;
    pos    = k_ext & (span - CMD_WIDTH'(1));
    addr_a = ((k_ext >> stage_q) << (stage_q + CMD_WIDTH'(1))) | pos;
    addr_b = addr_a + span;
    tw_sh  = CMD_WIDTH'(CMD_WIDTH - 1) - stage_q;
    tw_idx = KW'(pos << tw_sh);
  end

  // Addresses track the RAM read; wr_en follows rd_en through the butterfly.
  always_comb begin
    m_in_d    = m_in_q;
    if (run) m_in_d = {addr_b, addr_a};
    wr_pipe_d = {wr_pipe_q[BF_LATENCY-1:0], run};
  end

  // Control and alignment registers; reset aborts any transform in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      stage_q   <= '0;
      drain_q   <= '0;
      wr_pipe_q <= '0;
      m_in_q    <= '0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      stage_q   <= stage_d;
      drain_q   <= drain_d;
      wr_pipe_q <= wr_pipe_d;
      m_in_q    <= m_in_d;
      inv_q     <= inv_d;
    end
  end

  fft_twiddle_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .CMD_WIDTH  (CMD_WIDTH)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .idx   (tw_idx),
    .w     (w_rom)
  );

  // Conjugate twiddle for the inverse transform (im negated).
  always_comb begin
    w = w_rom;
`ifdef FFT_INVERSE_EN
    if (inv_q) w[2*DATA_WIDTH-1:DATA_WIDTH] = -w_rom[2*DATA_WIDTH-1:DATA_WIDTH];
`else
    w[0] = w_rom[0] | inv_q;
`endif
  end

  assign rd_en     = run;
  assign rd_addr_a = run ? addr_a : '0;
  assign rd_addr_b = run ? addr_b : '0;
  assign rd_bank   = stage_q[0];
  assign m_in      = m_in_q;
  assign wr_en     = wr_pipe_q[BF_LATENCY];
  assign stage     = stage_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

endmodule
